button_debounce: RTL

Input conditioning stage for the board's push buttons. It sits directly upstream of the delayed-reset generator and the user-input logic. Each raw, asynchronous button line is synchronised into the Clk domain and filtered with a per-channel stability counter. The block drives a clean level (for example BTNS into the reset generator) plus optional one-cycle press/release pulses.

---
 rtl/button_debounce_pkg.sv | 19 +
 rtl/button_debounce_channel.sv | 88 ++++++++
 rtl/button_debounce.sv | 30 +++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel state encoding
// and the default stability window used by simulation and hardware builds.
package button_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 5;

   // Logical channel state, derived from (Level, Count != 0).
   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      PEND_HIGH   = 2'b01,
      STABLE_HIGH = 2'b10,
      PEND_LOW    = 2'b11
   } db_state_t;

   function automatic db_state_t state_of(input logic level, input logic pending);
      return db_state_t'({level, pending});
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One debounced button channel: two-flop synchroniser, stability counter,
// accepted level and (with BUTTON_DEBOUNCE_EDGE_EN defined) press/release pulses.
module debounce_channel
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic Clk,
   input  logic nReset,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int COUNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);

   logic               s1;
   logic               s2;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] count_next;
   logic               level_next;
   logic               take;
   db_state_t          state;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         count <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         level <= level_next;
         count <= count_next;
      end
   end

   // Any sample agreeing with the current level cancels a pending change.
   always_comb begin
      count_next = count;
      level_next = level;
      take       = 1'b0;
      if (s2 == level) begin
         count_next = '0;
      end else if (count == LAST) begin
         level_next = s2;
         count_next = '0;
         take       = 1'b1;
      end else begin
         count_next = count + 1'b1;
      end
   end

`ifdef BUTTON_DEBOUNCE_EDGE_EN
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= take & s2;
         fall <= take & ~s2;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

   always_comb begin
      state = state_of(level, count != '0);
   end

   a_count_range : assert property (@(posedge Clk) disable iff (!nReset)
      count <= LAST);

   a_glitch_low : assert property (@(posedge Clk) disable iff (!nReset)
      (state == PEND_HIGH && s2 == 1'b0) |=> (state == STABLE_LOW));

   a_glitch_high : assert property (@(posedge Clk) disable iff (!nReset)
      (state == PEND_LOW && s2 == 1'b1) |=> (state == STABLE_HIGH));

   a_one_edge : assert property (@(posedge Clk) disable iff (!nReset)
      !(rise && fall));

endmodule

// File: rtl/button_debounce.sv
// Push-button input conditioning: WIDTH independent debounced channels.
// Optional Rise/Fall pulse registers are built when BUTTON_DEBOUNCE_EDGE_EN is defined.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic [WIDTH-1:0] Btn,
   output logic [WIDTH-1:0] Level,
   output logic [WIDTH-1:0] Rise,
   output logic [WIDTH-1:0] Fall
);

   for (genvar ch = 0; ch < WIDTH; ch++) begin : g_channel
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_channel (
         .Clk   (Clk),
         .nReset(nReset),
         .btn   (Btn[ch]),
         .level (Level[ch]),
         .rise  (Rise[ch]),
         .fall  (Fall[ch])
      );
   end

endmodule
